// File: rtl/wb_vector_arbiter.sv
// Write-back stage driving the scalar and vector register-file write ports.
// Convolution writes that lose the vector port wait in an in-order queue.
module wb_vector_arbiter #(
  parameter int LENGTH     = 16,
  parameter int INT8       = 8,
  parameter int INT32      = 32,
  parameter int CONV_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LENGTH*INT8-1:0]      conv_result,
  input  logic [4:0]                  conv_addr,
  input  logic                        conv_write,
  input  logic [4:0]                  rD,
  input  logic [INT32-1:0]            s_result,
  input  logic [LENGTH*INT8-1:0]      v_result,
  input  logic [INT32-1:0]            smem,
  input  logic [LENGTH*INT8-1:0]      vmem,
  input  logic                        ldr,
  input  logic [1:0]                  wb,
  output logic                        s_we,
  output logic [4:0]                  s_waddr,
  output logic [INT32-1:0]            s_wdata,
  output logic                        v_we,
  output logic [4:0]                  v_waddr,
  output logic [LENGTH*INT8-1:0]      v_wdata,
  output logic                        conv_full,
  output logic [$clog2(CONV_DEPTH):0] conv_count,
  output logic                        conv_overflow
);
  localparam int VW = LENGTH * INT8;
  localparam int PW = $clog2(CONV_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(CONV_DEPTH);

  logic [VW-1:0]         qdata_q [CONV_DEPTH];
  logic [4:0]            qaddr_q [CONV_DEPTH];
  logic [CONV_DEPTH-1:0] qvld_q, qvld_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;

  logic                  s_we_q, s_we_d;
  logic [4:0]            s_waddr_q, s_waddr_d;
  logic [INT32-1:0]      s_wdata_q, s_wdata_d;
  logic                  v_we_q, v_we_d;
  logic [4:0]            v_waddr_q, v_waddr_d;
  logic [VW-1:0]         v_wdata_q, v_wdata_d;

  logic pipe_v, empty, full;
  logic head_kill, head_live;
  logic grant_head, bypass;
  logic pop, push_req, push, drop;

  always_comb begin
    pipe_v     = (wb == 2'b10);
    empty      = (cnt_q == '0);
    full       = (cnt_q == DEPTH);
    head_kill  = pipe_v && (qaddr_q[head_q] == rD);
    head_live  = !empty && qvld_q[head_q] && !head_kill;
    grant_head = !pipe_v && head_live;
    bypass     = !pipe_v && empty && conv_write;
    pop        = !empty && (grant_head || !head_live);
    push_req   = conv_write && !bypass;
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
  end

  // Kill older entries first; a same-cycle push is newer and stays valid.
  always_comb begin
    qvld_d = qvld_q;
    for (int i = 0; i < CONV_DEPTH; i++) begin
      if (pipe_v && (qaddr_q[i] == rD)) qvld_d[i] = 1'b0;
    end
    if (pop)  qvld_d[head_q] = 1'b0;
    if (push) qvld_d[tail_q] = 1'b1;
    head_d = pop  ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    full_d = (cnt_d == DEPTH);
    ovf_d  = ovf_q | drop;
  end

  always_comb begin
    s_we_d    = (wb == 2'b01);
    s_waddr_d = '0;
    s_wdata_d = '0;
    if (s_we_d) begin
      s_waddr_d = rD;
      s_wdata_d = ldr ? smem : s_result;
    end
  end

  always_comb begin
    v_we_d    = 1'b0;
    v_waddr_d = '0;
    v_wdata_d = '0;
    unique case (1'b1)
      pipe_v: begin
        v_we_d    = 1'b1;
        v_waddr_d = rD;
        v_wdata_d = ldr ? vmem : v_result;
      end
      grant_head: begin
        v_we_d    = 1'b1;
        v_waddr_d = qaddr_q[head_q];
        v_wdata_d = qdata_q[head_q];
      end
      bypass: begin
        v_we_d    = 1'b1;
        v_waddr_d = conv_addr;
        v_wdata_d = conv_result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qvld_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      s_we_q    <= 1'b0;
      s_waddr_q <= '0;
      s_wdata_q <= '0;
      v_we_q    <= 1'b0;
      v_waddr_q <= '0;
      v_wdata_q <= '0;
    end else begin
      qvld_q    <= qvld_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      s_we_q    <= s_we_d;
      s_waddr_q <= s_waddr_d;
      s_wdata_q <= s_wdata_d;
      v_we_q    <= v_we_d;
      v_waddr_q <= v_waddr_d;
      v_wdata_q <= v_wdata_d;
    end
  end

  // Payload needs no reset: entries are only read while their valid bit is set.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      qdata_q[tail_q] <= conv_result;
      qaddr_q[tail_q] <= conv_addr;
    end
  end

  assign s_we          = s_we_q;
  assign s_waddr       = s_waddr_q;
  assign s_wdata       = s_wdata_q;
  assign v_we          = v_we_q;
  assign v_waddr       = v_waddr_q;
  assign v_wdata       = v_wdata_q;
  assign conv_full     = full_q;
  assign conv_count    = cnt_q;
  assign conv_overflow = ovf_q;

endmodule

// File: tb/tb_wb_vector_arbiter.sv
// Bench for wb_vector_arbiter: directed vector table, then random traffic
// checked against a queue-based reference model.
module tb_wb_vector_arbiter;
  localparam int LENGTH = 16;
  localparam int INT8   = 8;
  localparam int INT32  = 32;
  localparam int DEPTH  = 4;
  localparam int VW     = LENGTH * INT8;
  typedef logic [VW-1:0] vec_t;

  logic             clk = 1'b0;
  logic             reset;
  vec_t             conv_result, v_result, vmem;
  logic [4:0]       conv_addr, rD;
  logic             conv_write, ldr;
  logic [INT32-1:0] s_result, smem;
  logic [1:0]       wb;
  logic             s_we, v_we, conv_full, conv_overflow;
  logic [4:0]       s_waddr, v_waddr;
  logic [INT32-1:0] s_wdata;
  vec_t             v_wdata;
  logic [2:0]       conv_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_vector_arbiter #(
    .LENGTH(LENGTH), .INT8(INT8), .INT32(INT32), .CONV_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .conv_result(conv_result), .conv_addr(conv_addr),
    .conv_write(conv_write), .rD(rD),
    .s_result(s_result), .v_result(v_result),
    .smem(smem), .vmem(vmem), .ldr(ldr), .wb(wb),
    .s_we(s_we), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .v_we(v_we), .v_waddr(v_waddr), .v_wdata(v_wdata),
    .conv_full(conv_full), .conv_count(conv_count),
    .conv_overflow(conv_overflow)
  );

  typedef struct {
    bit               rst;
    logic             swe;
    logic [4:0]       swa;
    logic [INT32-1:0] sd;
    logic             vwe;
    logic [4:0]       vwa;
    vec_t             vd;
    logic [2:0]       cnt;
    logic             full;
    logic             ovf;
  } exp_t;

  typedef struct {
    bit         rst;
    logic [1:0] wb;
    bit         ldr;
    logic [4:0] rd;
    bit         cw;
    logic [4:0] ca;
    bit         swe;
    logic [4:0] swa;
    bit         ssrc;
    bit         vwe;
    logic [4:0] vwa;
    int         vsrc;
    int         vrow;
    int         cnt;
    bit         full;
    bit         ovf;
  } row_t;

  typedef struct {
    logic [4:0] a;
    vec_t       d;
    bit         v;
  } ent_t;

  task automatic chk(string nm, vec_t act, vec_t exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic check_all(string tag, exp_t e);
    chk({tag, " s_we"}, vec_t'(s_we), vec_t'(e.swe));
    if (e.swe || e.rst) begin
      chk({tag, " s_waddr"}, vec_t'(s_waddr), vec_t'(e.swa));
      chk({tag, " s_wdata"}, vec_t'(s_wdata), vec_t'(e.sd));
    end
    chk({tag, " v_we"}, vec_t'(v_we), vec_t'(e.vwe));
    if (e.vwe || e.rst) begin
      chk({tag, " v_waddr"}, vec_t'(v_waddr), vec_t'(e.vwa));
      chk({tag, " v_wdata"}, v_wdata, e.vd);
    end
    chk({tag, " conv_count"}, vec_t'(conv_count), vec_t'(e.cnt));
    chk({tag, " conv_full"}, vec_t'(conv_full), vec_t'(e.full));
    chk({tag, " conv_overflow"}, vec_t'(conv_overflow), vec_t'(e.ovf));
  endtask

  function automatic exp_t zero_exp(bit rst);
    exp_t e;
    e.rst = rst; e.swe = 0; e.swa = '0; e.sd = '0;
    e.vwe = 0; e.vwa = '0; e.vd = '0;
    e.cnt = '0; e.full = 0; e.ovf = 0;
    return e;
  endfunction

  function automatic logic [31:0] sres_f(int i);
    return 32'h100 + 32'(i);
  endfunction
  function automatic logic [31:0] smem_f(int i);
    return 32'hDEADBEEF ^ 32'(i);
  endfunction
  function automatic vec_t fill(int base, int i);
    logic [7:0] b;
    b = 8'(base + i);
    return {LENGTH{b}};
  endfunction

  function automatic row_t mk(bit rst, int wbv, bit l, int rd, bit cw, int ca,
                              bit swe, int swa, bit ssrc,
                              bit vwe, int vwa, int vsrc, int vrow,
                              int cnt, bit full, bit ovf);
    row_t r;
    r.rst = rst; r.wb = 2'(wbv); r.ldr = l; r.rd = 5'(rd);
    r.cw = cw; r.ca = 5'(ca);
    r.swe = swe; r.swa = 5'(swa); r.ssrc = ssrc;
    r.vwe = vwe; r.vwa = 5'(vwa); r.vsrc = vsrc; r.vrow = vrow;
    r.cnt = cnt; r.full = full; r.ovf = ovf;
    return r;
  endfunction

  task automatic idle_inputs();
    reset = 0; wb = 2'b00; ldr = 0; rD = '0;
    conv_write = 0; conv_addr = '0;
    s_result = '0; smem = '0;
    v_result = '0; vmem = '0; conv_result = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  row_t tbl[$];
  ent_t mq[$];
  bit   movf;

  // Reference: kill older matching entries, then pipeline > valid head >
  // bypass on an empty queue; a dead head is dropped; loser conv is queued.
  function automatic exp_t model_step();
    exp_t e;
    bit   popped, used;
    e = zero_exp(reset);
    if (reset) begin
      mq.delete();
      movf = 0;
      return e;
    end
    if (wb == 2'b01) begin
      e.swe = 1; e.swa = rD; e.sd = ldr ? smem : s_result;
    end
    popped = 0;
    used   = 0;
    if (wb == 2'b10) begin
      foreach (mq[i]) if (mq[i].a == rD) mq[i].v = 0;
      e.vwe = 1; e.vwa = rD; e.vd = ldr ? vmem : v_result;
    end else if (mq.size() > 0 && mq[0].v) begin
      e.vwe = 1; e.vwa = mq[0].a; e.vd = mq[0].d;
      void'(mq.pop_front());
      popped = 1;
    end else if (mq.size() == 0 && conv_write) begin
      e.vwe = 1; e.vwa = conv_addr; e.vd = conv_result;
      used = 1;
    end
    if (!popped && mq.size() > 0 && !mq[0].v) void'(mq.pop_front());
    if (conv_write && !used) begin
      if (mq.size() < DEPTH) begin
        ent_t n;
        n.a = conv_addr; n.d = conv_result; n.v = 1;
        mq.push_back(n);
      end else begin
        movf = 1;
      end
    end
    e.cnt  = 3'(mq.size());
    e.full = (mq.size() == DEPTH);
    e.ovf  = movf;
    return e;
  endfunction

  function automatic vec_t rvec();
    vec_t v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    // rst wb l rd cw ca | swe swa ss | vwe vwa vsrc vrow | cnt full ovf
    tbl.push_back(mk(0,1,1, 3,0, 0, 1, 3,1, 0, 0,0, 0, 0,0,0));
    tbl.push_back(mk(0,1,0,31,0, 0, 1,31,0, 0, 0,0, 0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,1, 7, 0, 0,0, 1, 7,3, 2, 0,0,0));
    tbl.push_back(mk(0,2,0, 2,1, 9, 0, 0,0, 1, 2,1, 3, 1,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0, 0, 0,0, 1, 9,3, 3, 0,0,0));
    tbl.push_back(mk(0,2,1, 1,1, 5, 0, 0,0, 1, 1,2, 5, 1,0,0));
    tbl.push_back(mk(0,2,0, 5,0, 0, 0, 0,0, 1, 5,1, 6, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0, 0, 0,0, 0, 0,0, 0, 0,0,0));
    tbl.push_back(mk(0,2,0,10,1,20, 0, 0,0, 1,10,1, 8, 1,0,0));
    tbl.push_back(mk(0,2,0,11,1,21, 0, 0,0, 1,11,1, 9, 2,0,0));
    tbl.push_back(mk(0,2,0,12,1,22, 0, 0,0, 1,12,1,10, 3,0,0));
    tbl.push_back(mk(0,2,0,13,1,23, 0, 0,0, 1,13,1,11, 4,1,0));
    tbl.push_back(mk(0,2,0,14,1,24, 0, 0,0, 1,14,1,12, 4,1,1));
    tbl.push_back(mk(0,0,0, 0,0, 0, 0, 0,0, 1,20,3, 8, 3,0,1));
    tbl.push_back(mk(0,0,0, 0,0, 0, 0, 0,0, 1,21,3, 9, 2,0,1));
    tbl.push_back(mk(0,0,0, 0,0, 0, 0, 0,0, 1,22,3,10, 1,0,1));
    tbl.push_back(mk(0,0,0, 0,0, 0, 0, 0,0, 1,23,3,11, 0,0,1));
    tbl.push_back(mk(0,0,0, 0,0, 0, 0, 0,0, 0, 0,0, 0, 0,0,1));
    tbl.push_back(mk(0,2,0, 1,1,12, 0, 0,0, 1, 1,1,18, 1,0,1));
    tbl.push_back(mk(0,2,0, 2,1,13, 0, 0,0, 1, 2,1,19, 2,0,1));
    tbl.push_back(mk(0,2,0, 3,1,14, 0, 0,0, 1, 3,1,20, 3,0,1));
    tbl.push_back(mk(1,0,0, 0,0, 0, 0, 0,0, 0, 0,0, 0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0, 0, 0,0, 0, 0,0, 0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0, 0, 0,0, 0, 0,0, 0, 0,0,0));
    tbl.push_back(mk(0,2,1, 6,1, 6, 0, 0,0, 1, 6,2,24, 1,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0, 0, 0,0, 1, 6,3,24, 0,0,0));
    tbl.push_back(mk(0,3,0, 4,0, 0, 0, 0,0, 0, 0,0, 0, 0,0,0));

    idle_inputs();
    reset = 1;
    tick();
    tick();
    check_all("reset", zero_exp(1));
    reset = 0;

    for (int r = 0; r < tbl.size(); r++) begin
      exp_t e;
      row_t t;
      t = tbl[r];
      reset = t.rst; wb = t.wb; ldr = t.ldr; rD = t.rd;
      conv_write = t.cw; conv_addr = t.ca;
      s_result = sres_f(r); smem = smem_f(r);
      v_result = fill(8'h80, r); vmem = fill(8'h40, r);
      conv_result = fill(8'hC0, r);
      tick();
      e = zero_exp(t.rst);
      e.swe = t.swe;
      e.swa = t.swa;
      e.sd  = t.swe ? (t.ssrc ? smem_f(r) : sres_f(r)) : '0;
      e.vwe = t.vwe;
      e.vwa = t.vwa;
      case (t.vsrc)
        1:       e.vd = fill(8'h80, t.vrow);
        2:       e.vd = fill(8'h40, t.vrow);
        3:       e.vd = fill(8'hC0, t.vrow);
        default: e.vd = '0;
      endcase
      e.cnt  = 3'(t.cnt);
      e.full = t.full;
      e.ovf  = t.ovf;
      check_all($sformatf("row%0d", r), e);
    end

    idle_inputs();
    reset = 1;
    mq.delete();
    movf = 0;
    void'(model_step());
    tick();
    check_all("rand reset", zero_exp(1));

    for (int c = 0; c < 3000; c++) begin
      exp_t e;
      reset = ($urandom_range(0, 99) == 0);
      wb    = 2'($urandom_range(0, 3));
      ldr   = 1'($urandom_range(0, 1));
      rD    = 5'($urandom_range(0, 7));
      conv_addr = 5'($urandom_range(0, 7));
      if (mq.size() == DEPTH && $urandom_range(0, 3) != 0)
        conv_write = 0;
      else
        conv_write = 1'($urandom_range(0, 1));
      s_result = $urandom; smem = $urandom;
      v_result = rvec(); vmem = rvec(); conv_result = rvec();
      e = model_step();
      tick();
      check_all($sformatf("rand%0d", c), e);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_vector_arbiter.md
# wb_vector_arbiter

Write-back stage that consumes the MEM/WB pipeline register outputs and drives the scalar and vector register-file write ports. Selects ALU vs. memory data per `ldr`/`wb`. Arbitrates the single vector write port between pipeline vector writes and convolution-unit writes, buffering deferred convolution writes in a small in-order queue. Sits between the MEM/WB register and the register files.

## Interface
- LENGTH, 16, vector lanes
- INT8, 8, lane width (bits)
- INT32, 32, scalar width (bits)
- CONV_DEPTH, 4, convolution write queue entries (power of 2, ≥2)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- conv_result  in  LENGTH*INT8  convolution write data
- conv_addr  in  5  convolution write register index
- conv_write  in  1  convolution write request (one per cycle)
- rD  in  5  pipeline destination register
- s_result  in  INT32  scalar ALU result
- v_result  in  LENGTH*INT8  vector ALU result
- smem  in  INT32  scalar load data
- vmem  in  LENGTH*INT8  vector load data
- ldr  in  1  1 = write load data, 0 = write ALU result
- wb  in  2  00 none, 01 scalar, 10 vector, 11 none (reserved)
- s_we / s_waddr / s_wdata  out  1 / 5 / INT32  scalar RF write port
- v_we / v_waddr / v_wdata  out  1 / 5 / LENGTH*INT8  vector RF write port
- conv_full  out  1  queue holds CONV_DEPTH entries
- conv_count  out  $clog2(CONV_DEPTH)+1  occupied entries
- conv_overflow  out  1  sticky: a convolution write was dropped

## Operation
- Scalar path: wb==01 → s_we=1, s_waddr=rD, s_wdata = ldr ? smem : s_result. Never contends.
- Vector port priority each cycle: (1) pipeline write (wb==10, data = ldr ? vmem : v_result, addr rD); (2) valid queue head; (3) incoming conv_write, only when queue empty (bypass).
- Incoming conv_write not granted the port is pushed at tail.
- Pop: head granted, or head invalid (killed). At most one pop per cycle; popping a killed head does not use the port.
- Kill: pipeline vector write to addr A clears valid on every queued entry with addr A (pipeline write is newer). A same-cycle incoming conv_write to A is newer than the pipeline write: pushed valid, not killed.
- Push when full: accepted only if a pop occurs the same cycle; otherwise dropped, conv_overflow set (cleared only by reset).
- conv_full = (conv_count == CONV_DEPTH). Upstream must stall convolution on conv_full.
- Pointers wrap modulo CONV_DEPTH; count saturates neither way (never exceeds bounds by construction).

## Timing
- All outputs registered. Latency 1: inputs sampled at edge N drive write ports during cycle N+1 (write ports valid for exactly one cycle per request).
- conv_full / conv_count reflect state after edge N; combinational use by upstream is from registered values only.
- Queued entry drains ≥1 cycle after push; head written the first cycle with no pipeline vector write.
- Reset (any time, including mid-drain): s_we=0, v_we=0, s_waddr=0, v_waddr=0, s_wdata=0, v_wdata=0, conv_full=0, conv_count=0, conv_overflow=0; queue emptied, pending entries discarded, no write issued the cycle after reset.

## Test plan
- Scalar: wb=01, rD=3, ldr=1, smem=0xDEADBEEF, s_result=0x1 → next cycle s_we=1, s_waddr=3, s_wdata=0xDEADBEEF; v_we=0.
- Bypass: queue empty, conv_write=1, conv_addr=7, wb=00 → next cycle v_we=1, v_waddr=7, v_wdata=conv_result; conv_count stays 0.
- Contention: wb=10 rD=2 and conv_write addr 9 same cycle → cycle+1 writes r2 (pipeline); conv_count=1; next idle cycle writes r9, conv_count=0.
- Kill: queue holds addr 5 (valid), pipeline vector write rD=5 → r5 written once with pipeline data; entry 5 popped without v_we; conv_count returns to 0.
- Full/overflow: 5 consecutive wb=10 with conv_write each cycle (distinct addrs) → conv_full after 4th push; 5th push dropped, conv_overflow=1; drain yields exactly 4 conv writes in arrival order.
- Reset mid-drain: queue count 3, assert reset 1 cycle → all outputs 0, no further conv writes issued.
